// File: rtl/prog_counter_pkg.sv
// Shared types and constants for the multi-mode programmable counter.
package prog_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/prog_counter_next.sv
// Next-state arithmetic: candidate count, overflow detection and terminal-count flag.
module prog_counter_next
  import prog_counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  count,
  input  logic              dir,
  input  mode_t             mode,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  count_nxt,
  output logic              ovf,
  output logic              tc_nxt
);

  logic [WIDTH:0] step_x, sum, diff;

  // One extra bit so neither the sum nor the borrow is lost.
  assign step_x = {{(WIDTH+1-STEP_W){1'b0}}, step};
  assign sum    = {1'b0, count} + step_x;
  assign diff   = {1'b0, count} - step_x;

  always_comb begin
    count_nxt = count;
    ovf       = 1'b0;
    tc_nxt    = 1'b0;
    if (step != '0) begin
      ovf = dir ? (sum > {1'b0, limit}) : (step_x > {1'b0, count});
      if (!ovf) begin
        count_nxt = dir ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
      end else begin
        case (mode)
          MODE_SAT, MODE_ONESHOT: begin
            // Pinned at the bound already: no fresh terminal-count event.
            count_nxt = dir ? limit : '0;
            tc_nxt    = (count != count_nxt);
          end
          default: begin
            count_nxt = dir ? '0 : limit;
            tc_nxt    = 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/prog_counter_mm.sv
// Multi-mode programmable counter: registers, control priority and sticky done flag.
module prog_counter_mm
  import prog_counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              dir,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  input  logic              clr_done,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              done
);

  mode_t           mode_e;
  logic [WIDTH-1:0] count_nxt;
  logic             ovf, tc_nxt, run;

  assign mode_e = mode_t'(mode);
  assign run    = en && !((mode_e == MODE_ONESHOT) && done);

  prog_counter_next #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_next (
    .count     (count),
    .dir       (dir),
    .mode      (mode_e),
    .limit     (limit),
    .step      (step),
    .count_nxt (count_nxt),
    .ovf       (ovf),
    .tc_nxt    (tc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else if (load) begin
      count <= (load_val > limit) ? limit : load_val;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (run) begin
        count <= count_nxt;
        tc    <= tc_nxt;
      end
      // Setting done wins over a coincident clear.
      if (run && ovf && (mode_e == MODE_ONESHOT)) done <= 1'b1;
      else if (clr_done)                          done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_counter_mm.sv
// Directed vector table plus randomized run against an arithmetic reference model.
module tb_prog_counter_mm;

  logic       clk = 1'b0;
  logic       rst, en, load, dir, clr_done;
  logic [7:0] load_val, limit;
  logic [1:0] mode;
  logic [3:0] step;
  logic [7:0] count;
  logic       tc, done;

  int n_cmp = 0;
  int n_bad = 0;

  int m_cnt;
  bit m_tc, m_done;

  typedef struct {
    bit       rst, load;
    bit [7:0] lv;
    bit       en, dir;
    bit [1:0] mode;
    bit [7:0] lim;
    bit [3:0] step;
    bit       clr;
    int       ec;
    bit       et, ed;
  } vec_t;

  vec_t tbl[$];

  prog_counter_mm #(.WIDTH(8), .STEP_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .mode     (mode),
    .limit    (limit),
    .step     (step),
    .clr_done (clr_done),
    .count    (count),
    .tc       (tc),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit r, bit ld, int lv, bit e, bit d, int md, int lim,
                              int st, bit c, int ec, bit et, bit ed);
    vec_t v;
    v.rst = r; v.load = ld; v.lv = lv[7:0]; v.en = e; v.dir = d; v.mode = md[1:0];
    v.lim = lim[7:0]; v.step = st[3:0]; v.clr = c; v.ec = ec; v.et = et; v.ed = ed;
    return v;
  endfunction

  // Reference model: counter as a plain integer, rules taken straight from the behaviour list.
  task automatic model_step();
    int  lim, nxt, bound;
    bit  ovf, set_done;
    lim = int'(limit);
    set_done = 1'b0;
    if (rst) begin
      m_cnt = 0; m_tc = 0; m_done = 0;
    end else if (load) begin
      m_cnt = (int'(load_val) > lim) ? lim : int'(load_val);
      m_tc = 0; m_done = 0;
    end else begin
      m_tc = 0;
      if (en && !(mode == 2 && m_done) && step != 0) begin
        nxt = dir ? m_cnt + int'(step) : m_cnt - int'(step);
        ovf = dir ? (nxt > lim) : (nxt < 0);
        if (!ovf) m_cnt = nxt;
        else if (mode == 1 || mode == 2) begin
          bound = dir ? lim : 0;
          m_tc  = (m_cnt != bound);
          m_cnt = bound;
          if (mode == 2) set_done = 1'b1;
        end else begin
          m_cnt = dir ? 0 : lim;
          m_tc  = 1;
        end
      end
      if (set_done) m_done = 1;
      else if (clr_done) m_done = 0;
    end
  endtask

  task automatic check(string nm, int ec, bit et, bit ed);
    n_cmp++;
    if (int'(count) != ec || tc !== et || done !== ed) begin
      n_bad++;
      $display("FAIL %s: got count=%0d tc=%0b done=%0b, want count=%0d tc=%0b done=%0b",
               nm, count, tc, done, ec, et, ed);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst = 1; en = 0; load = 0; dir = 1; clr_done = 0;
    load_val = 0; limit = 9; mode = 0; step = 1;

    // reset, then wrap up 0..9 -> 0
    tbl.push_back(mk(1,0,0,0,1,0,9,1,0, 0,0,0));
    for (int k = 1; k <= 9; k++) tbl.push_back(mk(0,0,0,1,1,0,9,1,0, k,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,9,1,0, 0,1,0));
    // saturate up from 190
    tbl.push_back(mk(0,1,190,0,1,1,200,15,0, 190,0,0));
    tbl.push_back(mk(0,0,0,1,1,1,200,15,0, 200,1,0));
    tbl.push_back(mk(0,0,0,1,1,1,200,15,0, 200,0,0));
    tbl.push_back(mk(0,0,0,1,1,1,200,15,0, 200,0,0));
    // one-shot down from 10, halt, clear, re-arm with coincident clr_done
    tbl.push_back(mk(0,1,10,0,0,2,200,4,0, 10,0,0));
    tbl.push_back(mk(0,0,0,1,0,2,200,4,0, 6,0,0));
    tbl.push_back(mk(0,0,0,1,0,2,200,4,0, 2,0,0));
    tbl.push_back(mk(0,0,0,1,0,2,200,4,0, 0,1,1));
    tbl.push_back(mk(0,0,0,1,0,2,200,4,0, 0,0,1));
    tbl.push_back(mk(0,0,0,1,0,2,200,4,0, 0,0,1));
    tbl.push_back(mk(0,0,0,0,0,2,200,4,1, 0,0,0));
    tbl.push_back(mk(0,0,0,1,0,2,200,4,1, 0,0,1));
    tbl.push_back(mk(0,0,0,1,0,2,200,4,0, 0,0,1));
    // load clamps, wins over en, clears done
    tbl.push_back(mk(0,1,250,1,1,0,100,1,0, 100,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,100,1,0, 0,1,0));
    // reset beats load/en at 57 with done set
    tbl.push_back(mk(0,1,57,0,1,2,57,5,0, 57,0,0));
    tbl.push_back(mk(0,0,0,1,1,2,57,5,0, 57,0,1));
    tbl.push_back(mk(1,1,80,1,1,2,57,5,0, 0,0,0));
    // step 0 holds
    tbl.push_back(mk(0,1,33,0,1,0,100,0,0, 33,0,0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0,0,0,1,1,0,100,0,0, 33,0,0));
    // limit lowered below count: up overflows, down proceeds
    tbl.push_back(mk(0,0,0,1,1,1,20,1,0, 20,1,0));
    tbl.push_back(mk(0,1,33,0,1,0,100,1,0, 33,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,20,3,0, 30,0,0));
    // reserved mode wraps down to limit
    tbl.push_back(mk(0,1,1,0,1,3,50,1,0, 1,0,0));
    tbl.push_back(mk(0,0,0,1,0,3,50,3,0, 50,1,0));
    // exact hit of limit is not overflow
    tbl.push_back(mk(0,1,7,0,1,0,10,3,0, 7,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,10,3,0, 10,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,10,3,0, 0,1,0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; load = tbl[i].load; load_val = tbl[i].lv; en = tbl[i].en;
      dir = tbl[i].dir; mode = tbl[i].mode; limit = tbl[i].lim; step = tbl[i].step;
      clr_done = tbl[i].clr;
      tick();
      check($sformatf("vec%0d", i), tbl[i].ec, tbl[i].et, tbl[i].ed);
    end

    limit = 8'd120;
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      load     = ($urandom_range(0, 7) == 0);
      load_val = 8'($urandom);
      en       = ($urandom_range(0, 3) != 0);
      dir      = 1'($urandom);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 31) == 0) limit = 8'($urandom);
      step     = 4'($urandom);
      clr_done = ($urandom_range(0, 7) == 0);
      tick();
      check($sformatf("rnd%0d", i), m_cnt, m_tc, m_done);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
